imem_loader: RTL and testbench

//  Byte-stream boot loader writing program words into instruction memory before the core runs.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_byte_packer.sv | 34 +++
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE,
        ERR
    } loader_state_t;

    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_BITS      = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian bytes into a 32-bit word: lane counter plus lane register.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_full
);

    logic [LANE_BITS-1:0] r_lane;
    logic [31:0]          r_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (clear) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (push) begin
            r_word[{r_lane, 3'b000} +: 8] <= byte_in;
            r_lane                        <= r_lane + 1'b1;
        end
    end

    // Asserted combinationally with the push that completes the word.
    assign word_full = push && (r_lane == LANE_BITS'(BYTES_PER_WORD - 1));
    assign word_out  = r_word;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> 32-bit instruction-memory writes, holding the core meanwhile.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_WIDTH);

    loader_state_t         r_state;
    logic [15:0]           r_len;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_ready;
    logic                  r_we;
    logic                  r_hold;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic        w_xfer;
    logic [15:0] w_len;
    logic        w_last;
    logic        w_clear;
    logic        w_push;
    logic        w_word_full;
    logic [31:0] w_word;

    assign w_xfer  = byte_valid & r_ready;
    assign w_len   = {byte_data, r_len[7:0]};
    assign w_last  = (17'(r_addr) + 17'd1) == {1'b0, r_len};
    assign w_clear = (r_state == LEN_HI) && w_xfer;
    assign w_push  = (r_state == DATA) && w_xfer;

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_clear),
        .push      (w_push),
        .byte_in   (byte_data),
        .word_out  (w_word),
        .word_full (w_word_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_addr  <= '0;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_hold  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE, ERR: begin
                    if (load_start) begin
                        r_state <= LEN_LO;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                        r_hold  <= 1'b1;
                        r_error <= 1'b0;
                    end
                end
                LEN_LO: begin
                    if (w_xfer) begin
                        r_len[7:0] <= byte_data;
                        r_state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (w_xfer) begin
                        r_len[15:8] <= byte_data;
                        if (w_len == 16'd0) begin
                            r_state <= DONE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_hold  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if ({1'b0, w_len} > CAPACITY) begin
                            r_state <= ERR;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= DATA;
                            r_addr  <= '0;
                        end
                    end
                end
                DATA: begin
                    if (w_push && w_word_full) begin
                        r_state <= WRITE;
                        r_ready <= 1'b0;
                        r_we    <= 1'b1;
                    end
                end
                WRITE: begin
                    // Address only advances when another word follows, so it never wraps.
                    if (w_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_hold  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= DATA;
                        r_addr  <= r_addr + 1'b1;
                        r_ready <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign byte_ready = r_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = w_word;
    assign core_hold  = r_hold;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: an ADDR_WIDTH=8 and an ADDR_WIDTH=2 instance share one stream.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        a_ready, a_we, a_hold, a_busy, a_done, a_error;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic        b_ready, b_we, b_hold, b_busy, b_done, b_error;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(8)) u_dut_a (
        .clk(clk), .reset(reset), .load_start(load_start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(a_ready),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .core_hold(a_hold), .busy(a_busy), .done(a_done), .error(a_error)
    );

    imem_loader #(.ADDR_WIDTH(2)) u_dut_b (
        .clk(clk), .reset(reset), .load_start(load_start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(b_ready),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .core_hold(b_hold), .busy(b_busy), .done(b_done), .error(b_error)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        ls;
        logic        v;
        logic [7:0]  d;
        logic [5:0]  exp_flags;   // {ready, we, hold, busy, done, error}
        logic [7:0]  exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    localparam logic [5:0] F_LOAD  = 6'b101100;
    localparam logic [5:0] F_WRITE = 6'b011100;
    localparam logic [5:0] F_DONE  = 6'b000010;
    localparam logic [5:0] F_IDLE  = 6'b000000;
    localparam logic [5:0] F_ERR   = 6'b001001;

    int    n_checks = 0;
    int    n_errors = 0;
    int    rdy_viol = 0;
    bit    sel = 1'b0;
    wr_t   qa[$];
    wr_t   qb[$];
    logic [31:0] exp_q[$];
    vec_t  vt[14];

    always @(negedge clk) begin
        if (!reset) begin
            if (a_we) qa.push_back(wr_t'{16'(a_addr), a_wdata});
            if (b_we) qb.push_back(wr_t'{16'(b_addr), b_wdata});
            if (a_busy && (a_ready == a_we)) rdy_viol++;
            if (b_busy && (b_ready == b_we)) rdy_viol++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [5:0] cur_flags();
        return sel ? {b_ready, b_we, b_hold, b_busy, b_done, b_error}
                   : {a_ready, a_we, a_hold, a_busy, a_done, a_error};
    endfunction

    task automatic do_reset();
        reset      = 1'b1;
        load_start = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        qa.delete();
        qb.delete();
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(posedge clk);
        #1 load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic r;
        byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 40; i++) begin
            r = cur_flags() >> 5;
            @(posedge clk);
            #1;
            if (r) begin
                byte_valid = 1'b0;
                return;
            end
        end
        byte_valid = 1'b0;
        n_checks++;
        n_errors++;
        $display("FAIL send_byte: byte %0h not accepted within 40 cycles", b);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic wait_done(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (cur_flags() & 6'b000010) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check(name, 64'(found), 64'd1);
    endtask

    task automatic check_writes(input string name);
        wr_t q[$];
        q = sel ? qb : qa;
        check({name, "_count"}, 64'(q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < q.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), 64'(q[i].addr), 64'(i));
            check($sformatf("%s_data%0d", name, i), 64'(q[i].data), 64'(exp_q[i]));
        end
    endtask

    initial begin
        // Test 1 vectors: inputs applied before an edge, outputs expected after it.
        vt[0]  = '{1'b1, 1'b0, 8'h00, F_LOAD,  8'h00, 32'h0};
        vt[1]  = '{1'b0, 1'b1, 8'h02, F_LOAD,  8'h00, 32'h0};
        vt[2]  = '{1'b0, 1'b1, 8'h00, F_LOAD,  8'h00, 32'h0};
        vt[3]  = '{1'b0, 1'b1, 8'h13, F_LOAD,  8'h00, 32'h0};
        vt[4]  = '{1'b0, 1'b1, 8'h00, F_LOAD,  8'h00, 32'h0};
        vt[5]  = '{1'b0, 1'b1, 8'h50, F_LOAD,  8'h00, 32'h0};
        vt[6]  = '{1'b0, 1'b1, 8'h00, F_WRITE, 8'h00, 32'h00500013};
        vt[7]  = '{1'b0, 1'b1, 8'hB3, F_LOAD,  8'h00, 32'h0};
        vt[8]  = '{1'b0, 1'b1, 8'hB3, F_LOAD,  8'h00, 32'h0};
        vt[9]  = '{1'b0, 1'b1, 8'h05, F_LOAD,  8'h00, 32'h0};
        vt[10] = '{1'b0, 1'b1, 8'h00, F_LOAD,  8'h00, 32'h0};
        vt[11] = '{1'b0, 1'b1, 8'h00, F_WRITE, 8'h01, 32'h000005B3};
        vt[12] = '{1'b0, 1'b0, 8'h00, F_DONE,  8'h00, 32'h0};
        vt[13] = '{1'b0, 1'b0, 8'h00, F_IDLE,  8'h00, 32'h0};

        // Reset state
        reset = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        #3;
        check("rst_a", {a_ready, a_we, a_hold, a_busy, a_done, a_error, a_addr, a_wdata}, '0);
        check("rst_b", {b_ready, b_we, b_hold, b_busy, b_done, b_error, b_addr, b_wdata}, '0);
        do_reset();
        check("idle_a", 64'({a_ready, a_we, a_hold, a_busy, a_done, a_error}), 64'(F_IDLE));

        // Test 1: table-driven N=2 load
        sel = 1'b0;
        for (int i = 0; i < 14; i++) begin
            load_start = vt[i].ls;
            byte_valid = vt[i].v;
            byte_data  = vt[i].d;
            @(posedge clk);
            #1;
            check($sformatf("t1_flags%0d", i), 64'(cur_flags()), 64'(vt[i].exp_flags));
            if (vt[i].exp_flags[4]) begin
                check($sformatf("t1_addr%0d", i), 64'(a_addr), 64'(vt[i].exp_addr));
                check($sformatf("t1_wdata%0d", i), 64'(a_wdata), 64'(vt[i].exp_wdata));
            end
        end
        load_start = 1'b0;
        byte_valid = 1'b0;
        exp_q = '{32'h00500013, 32'h000005B3};
        check_writes("t1");

        // Test 2: N=0
        do_reset();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("t2_done", 64'(cur_flags()), 64'(F_DONE));
        @(posedge clk);
        #1;
        check("t2_idle", 64'(cur_flags()), 64'(F_IDLE));
        check("t2_nowrite", 64'(qa.size()), 64'd0);

        // Test 3: oversize header on the 4-word instance, then recovery
        sel = 1'b1;
        do_reset();
        pulse_start();
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        check("t3_err", 64'(cur_flags()), 64'(F_ERR));
        byte_valid = 1'b1;
        byte_data  = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        check("t3_sticky", 64'(cur_flags()), 64'(F_ERR));
        pulse_start();
        check("t3_restart", 64'(cur_flags()), 64'(F_LOAD));
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hDEADBEEF, 0);
        wait_done("t3_done");
        exp_q = '{32'hDEADBEEF};
        check_writes("t3");

        // Test 4: 3 words, gap-free then with random valid gaps
        sel = 1'b0;
        exp_q = '{32'h11223344, 32'hA5A50F0F, 32'h80000001};
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            pulse_start();
            send_byte(8'h03, pass * 2);
            send_byte(8'h00, pass * 2);
            for (int w = 0; w < 3; w++) send_word(exp_q[w], pass * 3);
            wait_done($sformatf("t4_done%0d", pass));
            check_writes($sformatf("t4_pass%0d", pass));
        end

        // Test 5: reset in the middle of word 1
        do_reset();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h01020304, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        reset = 1'b1;
        #1;
        check("t5_rst_a", {a_ready, a_we, a_hold, a_busy, a_done, a_error, a_addr, a_wdata}, '0);
        check("t5_partial", 64'(qa.size()), 64'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("t5_idle", 64'(cur_flags()), 64'(F_IDLE));
        qa.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hCAFEF00D, 0);
        wait_done("t5_done");
        exp_q = '{32'hCAFEF00D};
        check_writes("t5");

        // Test 6: full-capacity load on the 4-word instance, load_start ignored in DATA
        sel = 1'b1;
        do_reset();
        exp_q = '{32'h00000093, 32'h00100113, 32'h002081B3, 32'h0000006F};
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int w = 0; w < 4; w++) begin
            send_byte(exp_q[w][7:0], 0);
            send_byte(exp_q[w][15:8], 0);
            if (w == 1 || w == 2) begin
                pulse_start();
                check($sformatf("t6_ignore%0d", w), 64'(cur_flags()), 64'(F_LOAD));
            end
            send_byte(exp_q[w][23:16], 0);
            send_byte(exp_q[w][31:24], 0);
        end
        wait_done("t6_done");
        check_writes("t6");
        check("t6_noerr", 64'(b_error), 64'd0);

        check("ready_vs_we", 64'(rdy_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
